// File: rtl/mul_err_monitor.sv
// Error-statistics monitor for an 8x8 approximate multiplier: observes operand/product
// samples, forms |exact - approx| and accumulates sum, max and nonzero-count over a run.
module mul_err_monitor #(
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a_op,
    input  logic [7:0]       b_op,
    input  logic [15:0]      approx_prod,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_err,
    output logic [15:0]      max_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] acc_cnt;
    logic             launch;
    logic             accept;
    logic             last_accept;

    logic             vld_p1;
    logic [15:0]      exact_p1;
    logic [15:0]      approx_p1;
    logic [15:0]      err_p1;

    // The difference is formed in 17-bit signed space so neither ordering can wrap.
    function automatic logic [15:0] abs_diff(input logic [15:0] x, input logic [15:0] y);
        logic signed [16:0] d;
        d = signed'({1'b0, x}) - signed'({1'b0, y});
        return (d < 0) ? 16'(-d) : 16'(d);
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [15:0] inc);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, inc};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign launch      = start && ((state == IDLE) || (state == DONE));
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (acc_cnt == (num_q - CNT_W'(1)));
    assign err_p1      = abs_diff(exact_p1, approx_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The final sample sits in stage 1 here; leave as it retires.
                if (vld_p1) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        in_ready = 1'b0;
        case (state)
            RUN: begin
                busy     = 1'b1;
                in_ready = (acc_cnt < num_q);
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q   <= '0;
            acc_cnt <= '0;
        end else if (launch) begin
            num_q   <= num_samples;
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    // Stage 1: capture exact product and the multiplier's answer on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            exact_p1  <= 16'(a_op) * 16'(b_op);
            approx_p1 <= approx_prod;
        end
    end

    // Stage 2: fold the error into the run statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_err    <= '0;
            max_err    <= '0;
            err_cnt    <= '0;
            sample_cnt <= '0;
        end else if (launch) begin
            sum_err    <= '0;
            max_err    <= '0;
            err_cnt    <= '0;
            sample_cnt <= '0;
        end else if (vld_p1) begin
            sum_err    <= sat_add(sum_err, err_p1);
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (err_p1 > max_err) begin
                max_err <= err_p1;
            end
            if (err_p1 != 16'd0) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mul_err_monitor.sv
// Directed and randomized bench for mul_err_monitor with a statistics reference model.
module tb_mul_err_monitor;

    localparam int CNT_W = 16;
    localparam int ACC_W = 17;
    localparam longint SAT = (longint'(1) << ACC_W) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a_op;
    logic [7:0]       b_op;
    logic [15:0]      approx_prod;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] sum_err;
    logic [15:0]      max_err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] sample_cnt;

    int checks   = 0;
    int failures = 0;

    longint exp_sum;
    int     exp_max;
    int     exp_errc;
    int     exp_cnt;

    mul_err_monitor #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_op        (a_op),
        .b_op        (b_op),
        .approx_prod (approx_prod),
        .busy        (busy),
        .done        (done),
        .sum_err     (sum_err),
        .max_err     (max_err),
        .err_cnt     (err_cnt),
        .sample_cnt  (sample_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_sum  = 0;
        exp_max  = 0;
        exp_errc = 0;
        exp_cnt  = 0;
    endtask

    task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int e;
        e = int'(a) * int'(b) - int'(p);
        if (e < 0) e = -e;
        exp_sum = (exp_sum + e > SAT) ? SAT : exp_sum + e;
        if (e > exp_max) exp_max = e;
        if (e != 0) exp_errc++;
        exp_cnt++;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_sum"},  64'(sum_err),    64'(exp_sum));
        check({tag, "_max"},  64'(max_err),    64'(exp_max));
        check({tag, "_errc"}, 64'(err_cnt),    64'(exp_errc));
        check({tag, "_cnt"},  64'(sample_cnt), 64'(exp_cnt));
    endtask

    task automatic do_start(input int n);
        num_samples = CNT_W'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
    endtask

    // Holds a sample on the inputs until it is taken, then leaves the bus idle.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int k;
        k = 0;
        a_op = a;
        b_op = b;
        approx_prod = p;
        in_valid = 1'b1;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        check("send_ready", 64'(in_ready), 64'd1);
        if (in_ready) model_accept(a, b, p);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k;
        k = 0;
        while (!done && k < bound) begin
            step();
            k++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        int acc;
        int k;
        logic [7:0] ra;
        logic [7:0] rb;

        rst = 1'b1;
        start = 1'b0;
        num_samples = '0;
        in_valid = 1'b0;
        a_op = '0;
        b_op = '0;
        approx_prod = '0;
        model_clear();

        #3;
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_done",  64'(done),       64'd0);
        check("rst_ready", 64'(in_ready),   64'd0);
        check("rst_sum",   64'(sum_err),    64'd0);
        check("rst_cnt",   64'(sample_cnt), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("idle_busy", 64'(busy), 64'd0);

        // Exact products: no error at all
        do_start(4);
        check("exact_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            send(ra, rb, 16'(ra) * 16'(rb));
        end
        wait_done("exact", 10);
        check("exact_sum", 64'(sum_err),    64'd0);
        check("exact_max", 64'(max_err),    64'd0);
        check("exact_errc", 64'(err_cnt),   64'd0);
        check("exact_cnt", 64'(sample_cnt), 64'd4);

        // Single error sample with latency probe
        do_start(1);
        check("one_ready", 64'(in_ready), 64'd1);
        send(8'd3, 8'd5, 16'd12);
        check("one_lat_cnt",  64'(sample_cnt), 64'd0);
        check("one_lat_done", 64'(done),       64'd0);
        step();
        check("one_done", 64'(done),    64'd1);
        check("one_sum",  64'(sum_err), 64'd3);
        check("one_max",  64'(max_err), 64'd3);
        check("one_errc", 64'(err_cnt), 64'd1);
        step();
        check("one_hold_done", 64'(done),    64'd1);
        check("one_hold_sum",  64'(sum_err), 64'd3);

        // Errors on both sides of the exact product
        do_start(2);
        send(8'd10, 8'd10, 16'd90);
        send(8'd5, 8'd10, 16'd58);
        wait_done("mix", 10);
        check("mix_sum",  64'(sum_err), 64'd18);
        check("mix_max",  64'(max_err), 64'd10);
        check("mix_errc", 64'(err_cnt), 64'd2);

        // Zero-length run
        do_start(0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check_stats("zero");

        // Saturation and the largest magnitudes in either direction
        do_start(3);
        send(8'd255, 8'd255, 16'd0);
        send(8'd255, 8'd255, 16'd0);
        send(8'd0, 8'd0, 16'hFFFF);
        wait_done("sat", 10);
        check("sat_sum", 64'(sum_err), 64'(SAT));
        check("sat_max", 64'(max_err), 64'd65535);
        check_stats("sat");

        // Randomly gapped stream of 16 samples
        do_start(16);
        acc = 0;
        k = 0;
        while (acc < 16 && k < 400) begin
            in_valid = 1'($urandom_range(0, 1));
            a_op = 8'($urandom);
            b_op = 8'($urandom);
            approx_prod = (16'(a_op) * 16'(b_op)) ^ 16'($urandom_range(0, 63));
            if (in_valid && in_ready) begin
                model_accept(a_op, b_op, approx_prod);
                acc++;
            end
            step();
            k++;
        end
        check("rand_accepts", 64'(acc), 64'd16);
        check("rand_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        wait_done("rand", 10);
        in_valid = 1'b0;
        check_stats("rand");

        // Start pulsed mid-run must not restart or resize the run
        do_start(4);
        send(8'd7, 8'd9, 16'd60);
        send(8'd2, 8'd2, 16'd4);
        num_samples = CNT_W'(9);
        start = 1'b1;
        step();
        start = 1'b0;
        check("srun_busy", 64'(busy), 64'd1);
        send(8'd20, 8'd20, 16'd405);
        send(8'd1, 8'd1, 16'd1);
        wait_done("srun", 10);
        check_stats("srun");
        check("srun_ready", 64'(in_ready), 64'd0);

        // Reset in the middle of an 8-sample run
        do_start(8);
        for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 16'($urandom));
        #2;
        rst = 1'b1;
        #1;
        check("mrst_busy",  64'(busy),       64'd0);
        check("mrst_done",  64'(done),       64'd0);
        check("mrst_ready", 64'(in_ready),   64'd0);
        check("mrst_sum",   64'(sum_err),    64'd0);
        check("mrst_max",   64'(max_err),    64'd0);
        check("mrst_errc",  64'(err_cnt),    64'd0);
        check("mrst_cnt",   64'(sample_cnt), 64'd0);
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        check("mrst_idle_busy",  64'(busy),       64'd0);
        check("mrst_idle_ready", 64'(in_ready),   64'd0);
        check("mrst_idle_cnt",   64'(sample_cnt), 64'd0);
        in_valid = 1'b0;

        do_start(8);
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            send(ra, rb, (16'(ra) * 16'(rb)) + 16'($urandom_range(0, 3)));
        end
        wait_done("post", 10);
        check_stats("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
